rgb_pwm_periph: RTL

Memory-mapped PWM peripheral on the core's data-memory bus, downstream of the multicycle core's load/store path. It turns core-written duty values into dimmed drive for the board LED and RGB channels. It provides a prescaled 8-bit PWM counter, glitch-free shadowed duty registers, and a sticky period-done flag that software can poll.

---
 rtl/rgb_pwm_periph_if.sv | 10 +
 rtl/rgb_pwm_periph.sv | 77 +++++++
 2 files changed

// File: rtl/rgb_pwm_periph_if.sv
// rgb_pwm_periph_if: data-memory bus between the core load/store path and the PWM peripheral
interface rgb_pwm_periph_if;
  logic        dmem_wren;
  logic [31:0] dmem_address;
  logic [2:0]  funct3;
  logic [31:0] dmem_data_in;
  logic [31:0] dmem_data_out;
  modport master (output dmem_wren, dmem_address, funct3, dmem_data_in, input dmem_data_out);
  modport slave (input dmem_wren, dmem_address, funct3, dmem_data_in, output dmem_data_out);
endinterface

// File: rtl/rgb_pwm_periph.sv
// rgb_pwm_periph: memory-mapped 4-channel PWM with prescaler, shadowed duties and sticky period flag
module rgb_pwm_periph #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0010,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  rgb_pwm_periph_if.slave bus,
  output logic led,
  output logic red,
  output logic green,
  output logic blue
);
  logic [4:0] ctrl;
  logic [PRESCALE_WIDTH-1:0] prescale, pre_cnt;
  logic [31:0] duty, shadow;
  logic [7:0] pwm_cnt;
  logic period_done;
  logic sel, we, run, run_nx, tick, wrap, clr;
  logic [1:0] off;
  logic [3:0] be;
  logic [31:0] wd, mask, rd;
  logic [4:0] ctrl_nx;
  logic [PRESCALE_WIDTH-1:0] pre_nx;
  logic [31:0] duty_nx;
  assign sel = bus.dmem_address[31:4] == BASE_ADDR[31:4];
  assign off = bus.dmem_address[3:2];
  assign we = bus.dmem_wren & sel;
  assign be = bus.funct3 == 3'b000 ? 4'b0001 << bus.dmem_address[1:0] :
              bus.funct3 == 3'b001 ? (bus.dmem_address[1] ? 4'b1100 : 4'b0011) :
              bus.funct3 == 3'b010 ? 4'b1111 : 4'b0000;
  assign wd = bus.funct3 == 3'b000 ? {4{bus.dmem_data_in[7:0]}} :
              bus.funct3 == 3'b001 ? {2{bus.dmem_data_in[15:0]}} : bus.dmem_data_in;
  assign mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign ctrl_nx = (ctrl & ~mask[4:0]) | (wd[4:0] & mask[4:0]);
  assign pre_nx = (prescale & ~mask[PRESCALE_WIDTH-1:0]) | (wd[PRESCALE_WIDTH-1:0] & mask[PRESCALE_WIDTH-1:0]);
  assign duty_nx = (duty & ~mask) | (wd & mask);
  assign run = ctrl[4];
  // counters clear on the very edge that drops run, so look at the incoming value
  assign run_nx = we && off == 2'd0 ? ctrl_nx[4] : run;
  assign tick = run & run_nx & (pre_cnt >= prescale);
  assign wrap = tick & (pwm_cnt == 8'hFF);
  assign clr = we & (off == 2'd3) & be[1] & wd[8];
  assign rd = off == 2'd0 ? 32'(ctrl) :
              off == 2'd1 ? 32'(prescale) :
              off == 2'd2 ? duty : {23'd0, period_done, pwm_cnt};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
      prescale <= '0;
      duty <= '0;
      shadow <= '0;
      pre_cnt <= '0;
      pwm_cnt <= '0;
      period_done <= 1'b0;
      bus.dmem_data_out <= '0;
      led <= 1'b0;
      red <= 1'b0;
      green <= 1'b0;
      blue <= 1'b0;
    end else begin
      if (we && off == 2'd0) ctrl <= ctrl_nx;
      if (we && off == 2'd1) prescale <= pre_nx;
      if (we && off == 2'd2) duty <= duty_nx;
      bus.dmem_data_out <= sel ? rd : '0;
      pre_cnt <= run & run_nx & ~tick ? pre_cnt + 1'b1 : '0;
      pwm_cnt <= !run_nx ? 8'd0 : tick ? pwm_cnt + 8'd1 : pwm_cnt;
      // shadow only reloads at period boundaries so a mid-period duty write cannot glitch
      if (!run || wrap) shadow <= duty;
      period_done <= wrap | (period_done & ~clr);
      led <= run & ctrl[0] & (pwm_cnt < shadow[7:0]);
      red <= run & ctrl[1] & (pwm_cnt < shadow[15:8]);
      green <= run & ctrl[2] & (pwm_cnt < shadow[23:16]);
      blue <= run & ctrl[3] & (pwm_cnt < shadow[31:24]);
    end
  end
endmodule
